// File: rtl/prio_grant_ctrl.sv
// 4-master priority grant controller: aged priorities, registered one-hot grant held
// until done or withdraw, with a watchdog that forces release of a stuck grant.
module prio_grant_ctrl #(
    parameter int AGE_TH  = 8,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] M,
    input  logic [2:0] P0,
    input  logic [2:0] P1,
    input  logic [2:0] P2,
    input  logic [2:0] P3,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_vld,
    output logic [1:0] gnt_id,
    output logic       timeout_err
);

    localparam int AW = (AGE_TH > 1) ? $clog2(AGE_TH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    id_nxt;
    logic          vld_nxt;
    logic          to_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic [2:0]    p    [4];
    logic [2:0]    age  [4];
    logic [AW-1:0] wcnt [4];
    logic [3:0]    sum  [4];
    logic [2:0]    eff  [4];

    logic [1:0]    win_id;
    logic [2:0]    win_eff;
    logic          win_hit;
    logic          grant_now;
    logic          rel;

    assign p[0] = P0;
    assign p[1] = P1;
    assign p[2] = P2;
    assign p[3] = P3;

    // Age is added in 4 bits so the saturation to 7 is exact.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = {1'b0, p[i]} + {1'b0, age[i]};
            eff[i] = sum[i][3] ? 3'd7 : sum[i][2:0];
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        win_id  = 2'd0;
        win_eff = 3'd0;
        win_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (M[i] && (!win_hit || (eff[i] > win_eff))) begin
                win_hit = 1'b1;
                win_eff = eff[i];
                win_id  = 2'(i);
            end
        end
    end

    assign grant_now = (state == IDLE) && win_hit;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        vld_nxt   = gnt_vld;
        to_nxt    = 1'b0;
        tcnt_nxt  = tcnt;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt  = 4'd0;
                id_nxt   = 2'd0;
                vld_nxt  = 1'b0;
                tcnt_nxt = '0;
                if (win_hit) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win_id;
                    id_nxt    = win_id;
                    vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                rel = done || !M[gnt_id] || (tcnt == TW'(TIMEOUT - 1));
                if (rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'd0;
                    id_nxt    = 2'd0;
                    vld_nxt   = 1'b0;
                    tcnt_nxt  = '0;
                    // done and withdraw take precedence over the watchdog
                    to_nxt    = !done && M[gnt_id];
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'd0;
                id_nxt    = 2'd0;
                vld_nxt   = 1'b0;
                tcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= 4'd0;
            gnt_id      <= 2'd0;
            gnt_vld     <= 1'b0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            gnt_id      <= id_nxt;
            gnt_vld     <= vld_nxt;
            timeout_err <= to_nxt;
            tcnt        <= tcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                age[i]  <= 3'd0;
                wcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!M[i] || gnt[i] || (grant_now && (win_id == 2'(i)))) begin
                    age[i]  <= 3'd0;
                    wcnt[i] <= '0;
                end else if (wcnt[i] == AW'(AGE_TH - 1)) begin
                    wcnt[i] <= '0;
                    if (age[i] != 3'd7) age[i] <= age[i] + 3'd1;
                end else begin
                    wcnt[i] <= wcnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prio_grant_ctrl.sv
// Bench for prio_grant_ctrl: directed scenarios plus random traffic, all compared
// against a cycle-level reference model of the arbitration, aging and watchdog rules.
module tb_prio_grant_ctrl;

    localparam int AGE_TH  = 8;
    localparam int TIMEOUT = 255;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] m    = 4'd0;
    logic [2:0] pr [4];
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       timeout_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // reference model state
    bit         busy;
    int         cur, start, cyc;
    int         w [4];
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic       exp_vld, exp_to;

    prio_grant_ctrl #(.AGE_TH(AGE_TH), .TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .rst(rst), .M(m),
        .P0(pr[0]), .P1(pr[1]), .P2(pr[2]), .P3(pr[3]),
        .done(done), .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int age_of(int i);
        int a;
        a = w[i] / AGE_TH;
        return (a > 7) ? 7 : a;
    endfunction

    task automatic model_reset();
        busy = 0; cur = 0; start = 0; cyc = 0;
        for (int i = 0; i < 4; i++) w[i] = 0;
        exp_gnt = 4'd0; exp_id = 2'd0; exp_vld = 1'b0; exp_to = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        int win, best, e;
        bit grant_now;
        win = -1; best = -1;
        exp_to = 1'b0;
        if (!busy) begin
            for (int i = 0; i < 4; i++) begin
                e = int'(pr[i]) + age_of(i);
                if (e > 7) e = 7;
                if (m[i] && e > best) begin best = e; win = i; end
            end
        end
        grant_now = !busy && (win >= 0);
        for (int i = 0; i < 4; i++) begin
            if (!m[i] || (grant_now && win == i) || (busy && cur == i)) w[i] = 0;
            else w[i] = w[i] + 1;
        end
        if (busy) begin
            if (done || !m[cur] || (cyc - start == TIMEOUT)) begin
                busy   = 0;
                exp_to = !done && m[cur];
            end
        end else if (grant_now) begin
            busy = 1; cur = win; start = cyc;
        end
        cyc = cyc + 1;
        exp_gnt = busy ? (4'b0001 << cur) : 4'd0;
        exp_id  = busy ? 2'(cur) : 2'd0;
        exp_vld = busy;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        m = 4'd0; done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        m = 4'b1111; pr[0] = 3'd1; pr[1] = 3'd1; pr[2] = 3'd1; pr[3] = 3'd7; rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({gnt, gnt_vld, gnt_id, timeout_err} !== 8'd0)
            $display("FAIL reset_hold gnt=%b vld=%b id=%0d to=%b required all 0", gnt, gnt_vld, gnt_id, timeout_err);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_vld !== 1'b1)
            $display("FAIL reset_first_grant gnt=%b id=%0d vld=%b required 1000/3/1", gnt, gnt_id, gnt_vld);
        else pass_cnt++;
        done = 1'b1; m = 4'd0;
        tick();
        done = 1'b0;
    endtask

    task automatic test_tie();
        go_idle();
        for (int i = 0; i < 4; i++) pr[i] = 3'd4;
        m = 4'b0110;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || {gnt, gnt_id} !== {exp_gnt, exp_id})
            $display("FAIL tie_lowest gnt=%b id=%0d required 0010/1", gnt, gnt_id);
        else pass_cnt++;
        done = 1'b1; m = 4'b0100;
        tick();
        done = 1'b0;
        chk_cnt++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL tie_gap gnt=%b vld=%b to=%b required 0000/0/0", gnt, gnt_vld, timeout_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt !== exp_gnt)
            $display("FAIL tie_next gnt=%b id=%0d required 0100/2", gnt, gnt_id);
        else pass_cnt++;
        done = 1'b1; m = 4'd0;
        tick();
        done = 1'b0;
    endtask

    task automatic test_starvation();
        bit starved_ok;
        bit got;
        go_idle();
        pr[0] = 3'd7; pr[1] = 3'd0; pr[2] = 3'd0; pr[3] = 3'd0;
        m = 4'b0011;
        starved_ok = 1;
        for (int k = 0; k < 200 && age_of(1) < 7; k++) begin
            done = exp_vld;
            tick();
            chk_cnt++;
            if ({gnt, gnt_id, gnt_vld, timeout_err} !== {exp_gnt, exp_id, exp_vld, exp_to})
                $display("FAIL starve_cycle%0d gnt=%b id=%0d to=%b required %b/%0d/%b", k, gnt, gnt_id, timeout_err, exp_gnt, exp_id, exp_to);
            else pass_cnt++;
            if (gnt[1] !== 1'b0) starved_ok = 0;
        end
        chk_cnt++;
        if (!starved_ok) $display("FAIL starve_m0_wins master1 granted=1 required 0 while P0=7");
        else pass_cnt++;
        pr[0] = 3'd6;
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            done = exp_vld;
            tick();
            if (gnt === 4'b0010) got = 1;
        end
        done = 1'b0;
        chk_cnt++;
        if (!got || gnt_id !== 2'd1 || exp_gnt !== 4'b0010)
            $display("FAIL starve_aged_grant gnt=%b id=%0d required 0010/1", gnt, gnt_id);
        else pass_cnt++;
        // master 0 now waits; the model tracks whether master 1 restarted from age 0
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            done = exp_vld && ($urandom_range(0, 1) == 1);
            tick();
            chk_cnt++;
            if ({gnt, gnt_id, gnt_vld} !== {exp_gnt, exp_id, exp_vld})
                $display("FAIL starve_after%0d gnt=%b required %b", k, gnt, exp_gnt);
            else pass_cnt++;
        end
        done = 1'b1; m = 4'd0;
        tick();
        done = 1'b0;
    endtask

    task automatic test_watchdog();
        int fall;
        go_idle();
        pr[2] = 3'd3;
        m = 4'b0100;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0100) $display("FAIL wdog_grant gnt=%b required 0100", gnt);
        else pass_cnt++;
        fall = -1;
        for (int k = 1; k <= 300 && fall < 0; k++) begin
            tick();
            if (gnt === 4'b0000) fall = k;
        end
        chk_cnt++;
        if (fall != TIMEOUT || timeout_err !== 1'b1 || exp_to !== 1'b1)
            $display("FAIL wdog_release fall_cycle=%0d to=%b required %0d/1", fall, timeout_err, TIMEOUT);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (timeout_err !== 1'b0 || gnt !== 4'b0100 || gnt !== exp_gnt)
            $display("FAIL wdog_pulse_width to=%b gnt=%b required 0/0100", timeout_err, gnt);
        else pass_cnt++;
        for (int k = 1; k < TIMEOUT; k++) tick();
        chk_cnt++;
        if (gnt !== 4'b0100) $display("FAIL wdog_hold_254 gnt=%b required 0100", gnt);
        else pass_cnt++;
        done = 1'b1;
        tick();
        done = 1'b0; m = 4'd0;
        chk_cnt++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b0 || exp_to !== 1'b0)
            $display("FAIL wdog_done_last gnt=%b to=%b required 0000/0", gnt, timeout_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL wdog_done_after to=%b required 0", timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_withdraw();
        go_idle();
        pr[0] = 3'd2; pr[3] = 3'd2;
        m = 4'b0001;
        tick(); tick(); tick();
        chk_cnt++;
        if (gnt !== 4'b0001) $display("FAIL wd_hold gnt=%b required 0001", gnt);
        else pass_cnt++;
        m = 4'b1000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b0 || {gnt, timeout_err} !== {exp_gnt, exp_to})
            $display("FAIL wd_release gnt=%b to=%b required 0000/0", gnt, timeout_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || timeout_err !== 1'b0)
            $display("FAIL wd_next gnt=%b id=%0d to=%b required 1000/3/0", gnt, gnt_id, timeout_err);
        else pass_cnt++;
        m = 4'd0;
        tick();
    endtask

    task automatic test_async_reset();
        go_idle();
        m = 4'b0010;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0010) $display("FAIL arst_pre gnt=%b required 0010", gnt);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({gnt, gnt_vld, gnt_id, timeout_err} !== 8'd0)
            $display("FAIL arst_immediate gnt=%b vld=%b id=%0d to=%b required all 0", gnt, gnt_vld, gnt_id, timeout_err);
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pr[0] = 3'd3; pr[1] = 3'd3;
        m = 4'b0011;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0001 || {gnt, gnt_id} !== {exp_gnt, exp_id} || timeout_err !== 1'b0)
            $display("FAIL arst_regrant gnt=%b id=%0d required 0001/0", gnt, gnt_id);
        else pass_cnt++;
        m = 4'd0;
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) m = 4'($urandom);
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < 4; i++) pr[i] = 3'($urandom);
            done = ($urandom_range(0, 5) == 0);
            tick();
            chk_cnt++;
            if ({gnt, gnt_id, gnt_vld, timeout_err} !== {exp_gnt, exp_id, exp_vld, exp_to}) begin
                $display("FAIL rand_cycle%0d gnt=%b id=%0d vld=%b to=%b required %b/%0d/%b/%b", k, gnt, gnt_id, gnt_vld, timeout_err, exp_gnt, exp_id, exp_vld, exp_to);
                bad++;
            end else pass_cnt++;
        end
        chk_cnt++;
        if (!$onehot0(gnt) || gnt_vld !== (|gnt))
            $display("FAIL rand_onehot gnt=%b vld=%b required onehot0 and vld=|gnt", gnt, gnt_vld);
        else pass_cnt++;
        done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pr[i] = 3'd0;
        model_reset();
        test_reset();
        test_tie();
        test_starvation();
        test_watchdog();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
